// File: rtl/dpram_arb_pkg.sv
// Shared types and client indices for the dual-port RAM access controller.
package dpram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int CLI_A = 0;
  localparam int CLI_B = 1;

endpackage

// File: rtl/dpram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the client not granted last wins.
module rr_arb2
  import dpram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 means client B held the most recent grant
  logic last_b_q, last_b_d;

  always_comb begin
    gnt = 2'b00;
    if (req[CLI_A] && (!req[CLI_B] || last_b_q)) begin
      gnt[CLI_A] = 1'b1;
    end else if (req[CLI_B]) begin
      gnt[CLI_B] = 1'b1;
    end
    last_b_d = last_b_q;
    if (gnt[CLI_A]) begin
      last_b_d = 1'b0;
    end else if (gnt[CLI_B]) begin
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one simple dual-port RAM between two clients; zero-sweeps the RAM after reset or clr.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int MSB      = 8,
  parameter int addrsize = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  output logic                busy,
  input  logic                a_wreq,
  input  logic [addrsize-1:0] a_waddr,
  input  logic [MSB-1:0]      a_wdata,
  output logic                a_wgnt,
  input  logic                b_wreq,
  input  logic [addrsize-1:0] b_waddr,
  input  logic [MSB-1:0]      b_wdata,
  output logic                b_wgnt,
  input  logic                a_rreq,
  input  logic [addrsize-1:0] a_raddr,
  output logic                a_rgnt,
  output logic [MSB-1:0]      a_rdata,
  output logic                a_rvalid,
  input  logic                b_rreq,
  input  logic [addrsize-1:0] b_raddr,
  output logic                b_rgnt,
  output logic [MSB-1:0]      b_rdata,
  output logic                b_rvalid,
  output logic                ram_we,
  output logic [addrsize-1:0] ram_wa,
  output logic [MSB-1:0]      ram_wd,
  output logic [addrsize-1:0] ram_ra,
  input  logic [MSB-1:0]      ram_rd
);

  state_e              state_q;
  logic [addrsize-1:0] cnt_q;
  logic                run;
  logic [1:0]          wreq, wgnt, rreq, rgnt;
  logic [MSB-1:0]      a_rdata_q, b_rdata_q;
  logic                a_rvalid_q, b_rvalid_q;

  assign run  = (state_q == ST_RUN);
  assign busy = !run;

  // Requests are masked during the sweep so neither pointer moves.
  assign wreq = {b_wreq & run, a_wreq & run};
  assign rreq = {b_rreq & run, a_rreq & run};

  rr_arb2 u_warb (.clk(clk), .rst_n(rst_n), .req(wreq), .gnt(wgnt));
  rr_arb2 u_rarb (.clk(clk), .rst_n(rst_n), .req(rreq), .gnt(rgnt));

  assign a_wgnt = wgnt[CLI_A];
  assign b_wgnt = wgnt[CLI_B];
  assign a_rgnt = rgnt[CLI_A];
  assign b_rgnt = rgnt[CLI_B];

  always_comb begin
    ram_we = 1'b1;
    ram_wa = cnt_q;
    ram_wd = '0;
    if (run) begin
      ram_we = |wgnt;
      ram_wa = wgnt[CLI_B] ? b_waddr : a_waddr;
      ram_wd = wgnt[CLI_B] ? b_wdata : a_wdata;
    end
  end

  assign ram_ra = rgnt[CLI_B] ? b_raddr : (rgnt[CLI_A] ? a_raddr : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (cnt_q == {addrsize{1'b1}}) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (clr) begin
            state_q <= ST_CLEAR;
          end
        end
      endcase
    end
  end

  // The RAM read is asynchronous, so capture happens at the edge closing the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= rgnt[CLI_A];
      b_rvalid_q <= rgnt[CLI_B];
      if (rgnt[CLI_A]) a_rdata_q <= ram_rd;
      if (rgnt[CLI_B]) b_rdata_q <= ram_rd;
    end
  end

  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Randomized and directed bench for dpram_arbiter against a behavioural model and a RAM model.
module tb_dpram_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          busy;
  logic          a_wreq = 1'b0, b_wreq = 1'b0, a_rreq = 1'b0, b_rreq = 1'b0;
  logic [AW-1:0] a_waddr = '0, b_waddr = '0, a_raddr = '0, b_raddr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_wgnt, b_wgnt, a_rgnt, b_rgnt;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid;
  logic          ram_we;
  logic [AW-1:0] ram_wa, ram_ra;
  logic [DW-1:0] ram_wd, ram_rd;

  always #5 clk = ~clk;

  dpram_arbiter #(.MSB(DW), .addrsize(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .a_wreq(a_wreq), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_wgnt(a_wgnt),
    .b_wreq(b_wreq), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_wgnt(b_wgnt),
    .a_rreq(a_rreq), .a_raddr(a_raddr), .a_rgnt(a_rgnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_rreq(b_rreq), .b_raddr(b_raddr), .b_rgnt(b_rgnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_wd(ram_wd), .ram_ra(ram_ra), .ram_rd(ram_rd)
  );

  // The physical RAM the controller drives: synchronous write, asynchronous read.
  logic [DW-1:0] ram_env [DEPTH];
  always @(posedge clk) if (ram_we) ram_env[ram_wa] <= ram_wd;
  assign ram_rd = ram_env[ram_ra];

  // Reference model state
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            exp_run;
  int            exp_cnt;
  int            w_last, r_last;   // client index of the last grant
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_a_rd, exp_b_rd;
  bit            exp_a_rv, exp_b_rv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_run  = 1'b0;
    exp_cnt  = 0;
    w_last   = 1;
    r_last   = 1;
    exp_a_rd = '0;
    exp_b_rd = '0;
    exp_a_rv = 1'b0;
    exp_b_rv = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_gnt", 32'({a_wgnt, b_wgnt, a_rgnt, b_rgnt}), 32'd0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd1);
    chk("rst_ram_wa", 32'(ram_wa), 32'd0);
    chk("rst_ram_wd", 32'(ram_wd), 32'd0);
    chk("rst_ram_ra", 32'(ram_ra), 32'd0);
  endtask

  function automatic int pick(input bit ra, input bit rb, input int last);
    // returns -1 for no grant, else the winning client
    if (ra && rb) return (last == 0) ? 1 : 0;
    if (ra) return 0;
    if (rb) return 1;
    return -1;
  endfunction

  // One clock cycle: called at posedge+1 with inputs already driven.
  task automatic cycle(input bit rst_mid);
    int            wc, rc;
    bit            e_we;
    logic [AW-1:0] e_wa, e_ra;
    logic [DW-1:0] e_wd;
    #3;
    wc = exp_run ? pick(a_wreq, b_wreq, w_last) : -1;
    rc = exp_run ? pick(a_rreq, b_rreq, r_last) : -1;
    e_we = !exp_run || (wc >= 0);
    e_wa = !exp_run ? AW'(exp_cnt) : ((wc == 1) ? b_waddr : a_waddr);
    e_wd = !exp_run ? '0 : ((wc == 1) ? b_wdata : a_wdata);
    e_ra = (rc == 0) ? a_raddr : ((rc == 1) ? b_raddr : '0);
    chk("busy", 32'(busy), 32'(!exp_run));
    chk("grants", 32'({a_wgnt, b_wgnt, a_rgnt, b_rgnt}),
        32'({wc == 0, wc == 1, rc == 0, rc == 1}));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    if (e_we) begin
      chk("ram_wa", 32'(ram_wa), 32'(e_wa));
      chk("ram_wd", 32'(ram_wd), 32'(e_wd));
    end
    chk("ram_ra", 32'(ram_ra), 32'(e_ra));
    if (exp_run && (wc >= 0 || rc >= 0))
      $display("[TB] t=%0t wgnt=%0d wa=%02h wd=%02h rgnt=%0d ra=%02h clr=%0d",
               $time, wc, e_wa, e_wd, rc, e_ra, clr);
    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      check_reset();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_reset();
      return;
    end
    // reads see the contents before this cycle's write
    exp_a_rv = (rc == 0);
    exp_b_rv = (rc == 1);
    if (rc == 0) exp_a_rd = mem[e_ra];
    if (rc == 1) exp_b_rd = mem[e_ra];
    if (e_we) mem[e_wa] = e_wd;
    if (wc >= 0) w_last = wc;
    if (rc >= 0) r_last = rc;
    if (!exp_run) begin
      if (exp_cnt == DEPTH - 1) begin
        exp_run = 1'b1;
        exp_cnt = 0;
      end else begin
        exp_cnt++;
      end
    end else if (clr) begin
      exp_run = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("a_rvalid", 32'(a_rvalid), 32'(exp_a_rv));
    chk("b_rvalid", 32'(b_rvalid), 32'(exp_b_rv));
    chk("a_rdata", 32'(a_rdata), 32'(exp_a_rd));
    chk("b_rdata", 32'(b_rdata), 32'(exp_b_rd));
  endtask

  task automatic idle_inputs();
    a_wreq = 0; b_wreq = 0; a_rreq = 0; b_rreq = 0; clr = 0;
  endtask

  task automatic rand_inputs(input bit allow_clr);
    a_wreq  = 1'($urandom);
    b_wreq  = 1'($urandom);
    a_rreq  = 1'($urandom);
    b_rreq  = 1'($urandom);
    a_waddr = AW'($urandom_range(0, 15));
    b_waddr = AW'($urandom_range(0, 15));
    a_raddr = AW'($urandom_range(0, 15));
    b_raddr = AW'($urandom_range(0, 15));
    a_wdata = DW'($urandom);
    b_wdata = DW'($urandom);
    clr     = allow_clr && ($urandom_range(0, 149) == 0);
  endtask

  task automatic finish_sweep();
    while (!exp_run) begin
      rand_inputs(1'b0);
      cycle(1'b0);
    end
    idle_inputs();
  endtask

  task automatic readback_all();
    for (int i = 0; i < DEPTH; i++) begin
      b_rreq  = 1'b1;
      b_raddr = AW'(i);
      cycle(1'b0);
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
    model_reset();
    #2;
    check_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // initial sweep with requests asserted (must be ignored), then full readback
    finish_sweep();
    readback_all();

    // both clients write continuously: grants alternate starting with A
    a_wreq = 1; a_waddr = 8'h10; a_wdata = 8'hAA;
    b_wreq = 1; b_waddr = 8'h20; b_wdata = 8'hBB;
    repeat (4) cycle(1'b0);
    idle_inputs();
    b_rreq = 1; b_raddr = 8'h10; cycle(1'b0);
    b_raddr = 8'h20; cycle(1'b0);
    idle_inputs();

    // same-cycle write and read of one address returns the old value
    a_wreq = 1; a_waddr = 8'h03; a_wdata = 8'h55;
    b_rreq = 1; b_raddr = 8'h03;
    cycle(1'b0);
    a_wreq = 0;
    cycle(1'b0);
    idle_inputs();

    // clr while A's write is granted: write lands, then the sweep clears it
    a_wreq = 1; a_waddr = 8'h05; a_wdata = 8'h77; clr = 1;
    cycle(1'b0);
    idle_inputs();
    finish_sweep();
    readback_all();

    // randomized traffic, occasional clr
    repeat (600) begin
      rand_inputs(1'b1);
      cycle(1'b0);
    end
    idle_inputs();
    finish_sweep();

    // reset during a read grant drops the pending rvalid
    b_rreq = 1; b_raddr = 8'h05;
    cycle(1'b1);
    idle_inputs();
    finish_sweep();

    // reset mid-sweep when ram_wa = 7, sweep restarts from 0
    clr = 1;
    cycle(1'b0);
    clr = 0;
    while (exp_cnt != 7) cycle(1'b0);
    cycle(1'b1);
    finish_sweep();
    repeat (100) begin
      rand_inputs(1'b0);
      cycle(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_arbiter.md
# dpram_arbiter

Two-client access controller for the team's simple dual-port RAM (one synchronous write port, one asynchronous read port). It shares the RAM's write port and read port between clients A and B using round-robin arbitration. It registers read data back to the granted client. After reset, or on request, it sweeps the whole RAM to zero before it serves any client.

## Interface
Parameters:
- MSB, 8: data width in bits.
- addrsize, 8: address width in bits; depth = 1<<addrsize.

Ports (clock and reset first):
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  one-cycle pulse; starts a zero sweep. Honoured only in RUN.
- busy  out  1  high while in CLEAR.
- a_wreq, b_wreq  in  1  write request; held until granted.
- a_waddr, b_waddr  in  addrsize  write address.
- a_wdata, b_wdata  in  MSB  write data.
- a_wgnt, b_wgnt  out  1  write grant; combinational, same cycle as the request.
- a_rreq, b_rreq  in  1  read request; held until granted.
- a_raddr, b_raddr  in  addrsize  read address.
- a_rgnt, b_rgnt  out  1  read grant; combinational.
- a_rdata, b_rdata  out  MSB  registered read data.
- a_rvalid, b_rvalid  out  1  one-cycle pulse; rdata is valid.
- ram_we  out  1  RAM write enable.
- ram_wa  out  addrsize  RAM write address.
- ram_wd  out  MSB  RAM write data.
- ram_ra  out  addrsize  RAM read address.
- ram_rd  in  MSB  RAM read data (combinational from ram_ra).

## Operation
- FSM states: CLEAR, RUN.
- Reset enters CLEAR with the sweep counter at 0.
- CLEAR:
  - ram_we=1, ram_wa=counter, ram_wd=0.
  - Counter increments each cycle.
  - When counter = depth-1, the FSM moves to RUN next cycle and the counter returns to 0.
  - All grants and rvalids are 0.
  - clr is ignored.
- RUN, clr=1: the FSM enters CLEAR next cycle. Grants in that cycle are still honoured.
- Write arbitration (RUN):
  - One request: that client is granted.
  - Both request: grant the client not granted on the last write grant.
  - The pointer updates only on a grant.
  - Pointer reset value is "B last", so A wins the first tie.
- Granted write: ram_we=1, ram_wa/ram_wd = granted client's address/data. No grant means ram_we=0.
- Read arbitration (RUN): same scheme with an independent pointer, also reset to "B last".
  - ram_ra = granted client's raddr; otherwise ram_ra = 0.
  - On a read grant, ram_rd is captured into that client's rdata, and its rvalid pulses the next cycle.
  - rdata holds its value until the next capture for that client.
- Read and write grants are independent; both may issue in the same cycle.
- Same-cycle read and write to the same address: the read returns the pre-write (old) value.

## Timing
- Reset values: busy=1, all grants=0, all rvalids=0, all rdata=0, ram_we=1, ram_wa=0, ram_wd=0, ram_ra=0.
- Sweep length: exactly depth cycles.
  - busy falls on the edge after the cycle with ram_wa=depth-1.
  - The first grant is possible in that same cycle.
- Write latency: the RAM is updated at the edge closing the grant cycle.
- Read latency: 1 cycle from grant to rvalid.
- Back-to-back grants to one client: allowed every cycle when the other client is idle.
- Boundary conditions:
  - Counter wrap is not possible; the FSM exits at depth-1.
  - rst_n asserted mid-sweep or mid-read: immediate return to reset values; a pending rvalid is dropped.
  - clr in the same cycle as grants: grants complete; the sweep starts next cycle.

## Structure
- Package dpram_arb_pkg:
  - state enum {ST_CLEAR, ST_RUN}.
  - Client index constants CLI_A=0, CLI_B=1.
- Sub-module rr_arb2:
  - Two-requester round-robin arbiter: req[1:0] in, gnt[1:0] out, last-grant register inside.
  - Instantiated twice: once for writes, once for reads.

## Test plan
- Reset release, addrsize=4: ram_we=1 for 16 cycles with ram_wa 0..15 and ram_wd=0; busy falls after cycle 16; reading any address returns 0.
- A and B both write continuously, A to 0x10 with 0xAA, B to 0x20 with 0xBB: grants alternate A,B,A,B starting with A; RAM holds 0xAA at 0x10 and 0xBB at 0x20.
- A writes 0x55 to 0x03 while B reads 0x03 in the same cycle: b_rdata=0x00 (old value) with b_rvalid one cycle later; a subsequent B read returns 0x55.
- Only B reads, addresses 1,2,3 in consecutive cycles: b_rgnt high for 3 cycles, b_rvalid high for 3 cycles starting one cycle later, data in address order; a_rvalid stays 0.
- clr pulse in RUN while A's write is granted: the write lands; busy=1 next cycle; after depth cycles, all locations read 0.
- rst_n low mid-sweep at ram_wa=7: outputs return to reset values immediately; after release the sweep restarts at 0.
